// File: rtl/fft_bram_axis_unloader.sv
// -----------------------------------------------------------------------------
// fft_bram_axis_unloader
//   Reader end of the FFT buffer path. Drains a completed in-place FFT frame
//   from the shared data BRAM (always-enabled, fixed read latency) and emits it
//   as an AXI-Stream master. Each word_t {left, right} pair is forwarded as-is.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset (release is
//                        expected to be synchronised upstream)
//   start                one-cycle pulse, begins a frame (ignored while busy)
//   busy                 high from the accepted start until the last beat
//   done                 one-cycle pulse on the cycle after the tlast handshake
//   bram_we, bram_din    write side of the BRAM port, tied off (read only)
//   bram_addr            registered byte address of the current read
//   bram_dout            read data, valid READ_LAT cycles after bram_addr
//   m_tdata/m_tvalid/    AXI-Stream master
//   m_tready/m_tlast
// -----------------------------------------------------------------------------
module fft_bram_axis_unloader #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int N_WORDS   = 512,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 4,
  parameter int READ_LAT  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  localparam int FIFO_DEPTH = READ_LAT + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W     = $clog2(N_WORDS + 1);
  // Holds FIFO occupancy plus every outstanding read tag (at most 2*READ_LAT+3).
  localparam int OCC_W      = $clog2(2 * READ_LAT + 4);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [BEAT_W-1:0]    issued_r;
  logic [BEAT_W-1:0]    beat_r;
  logic [ADDR_W-1:0]    addr_r;
  logic                 addr_vld_r;
  logic [READ_LAT-1:0]  tag_r;
  logic [DATA_W-1:0]    fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     fifo_count_r;
  logic                 done_r;

  logic                 issue_s;
  logic [BEAT_W-1:0]    issue_idx_s;
  logic [ADDR_W-1:0]    issue_addr_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 last_hs_s;
  logic [OCC_W-1:0]     occ_s;
  logic                 credit_ok_s;

  // Wrap a FIFO pointer at FIFO_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign bram_we   = 1'b0;
  assign bram_din  = '0;
  assign bram_addr = addr_r;
  assign busy      = (state_r == ST_RUN);
  assign done      = done_r;

  assign m_tvalid  = (fifo_count_r != '0);
  // Gated so the stream data is zero whenever nothing is offered (and in reset).
  assign m_tdata   = m_tvalid ? fifo_mem_r[rd_ptr_r] : '0;
  assign m_tlast   = m_tvalid & (beat_r == BEAT_W'(N_WORDS - 1));

  assign pop_s     = m_tvalid & m_tready;
  assign push_s    = tag_r[READ_LAT-1];
  assign last_hs_s = pop_s & m_tlast;

  // Credit: FIFO occupancy after this cycle's pop plus all reads still in the
  // BRAM pipe must leave room for one more read, so a push never meets a full
  // FIFO while the head is draining one beat per cycle.
  always_comb begin
    occ_s = OCC_W'(fifo_count_r) + OCC_W'(addr_vld_r);
    for (int i = 0; i < READ_LAT; i++) begin
      occ_s = occ_s + OCC_W'(tag_r[i]);
    end
    if (pop_s) begin
      occ_s = occ_s - OCC_W'(1);
    end else begin
      occ_s = occ_s;
    end
    credit_ok_s = (occ_s < OCC_W'(FIFO_DEPTH));
  end

  // Next-state and read-issue decision. The first read issues on the edge
  // that accepts start, which gives the READ_LAT+1 first-beat latency.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    issue_idx_s  = issued_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
          issue_s      = 1'b1;
          issue_idx_s  = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((issued_r < BEAT_W'(N_WORDS)) && credit_ok_s) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
        if (last_hs_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    issue_addr_s = ADDR_W'(BASE_ADDR) + ADDR_W'(issue_idx_s) * ADDR_W'(ADDR_STEP);
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= last_hs_s;
    end
  end

  // Read index, BRAM address register and the read-latency tag pipe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issued_r   <= '0;
      addr_r     <= ADDR_W'(BASE_ADDR);
      addr_vld_r <= 1'b0;
      tag_r      <= '0;
    end else begin
      if (issue_s) begin
        issued_r <= issue_idx_s + BEAT_W'(1);
        addr_r   <= issue_addr_s;
      end
      addr_vld_r <= issue_s;
      tag_r[0]   <= addr_vld_r;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Beat counter, restarted whenever the block is idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_r <= '0;
    end else if (state_r == ST_IDLE) begin
      beat_r <= '0;
    end else if (pop_s) begin
      beat_r <= beat_r + BEAT_W'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bram_dout;
    end
  end

endmodule

// File: tb/tb_fft_bram_axis_unloader.sv
// -----------------------------------------------------------------------------
// Bench for fft_bram_axis_unloader. Main instance: N_WORDS=512, READ_LAT=2,
// BASE_ADDR=0x400, BRAM[i]=i. Three extra instances with N_WORDS=1 and
// READ_LAT=1..3 cover the single-beat frame and the latency sweep.
// Expected beats are queued when a frame is started; a negedge monitor pops
// and compares every handshake.
// -----------------------------------------------------------------------------
module tb_fft_bram_axis_unloader;

  localparam int N     = 512;
  localparam int RL    = 2;
  localparam int BASE  = 32'h400;
  localparam int DEPTH = RL + 2;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        busy, done, bram_we, m_tvalid, m_tready, m_tlast;
  logic [13:0] bram_addr;
  logic [31:0] bram_din, bram_dout, m_tdata;
  logic [31:0] rd_p1, rd_p2;

  logic [2:0]  sm_start, sm_busy, sm_done, sm_we, sm_tvalid, sm_tlast;
  logic [13:0] sm_addr  [3];
  logic [31:0] sm_din   [3];
  logic [31:0] sm_dout  [3];
  logic [31:0] sm_tdata [3];

  int    checks = 0;
  int    errors = 0;
  int    beats_seen = 0;
  int    rdy_mode = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  fft_bram_axis_unloader #(
    .ADDR_W(14), .DATA_W(32), .N_WORDS(N), .BASE_ADDR(BASE),
    .ADDR_STEP(4), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast)
  );

  function automatic logic [31:0] bram_model(input logic [13:0] a);
    int idx;
    idx = (int'(a) - BASE) / 4;
    if (int'(a) >= BASE && idx < N && a[1:0] == 2'b00) begin
      return 32'(idx);
    end else begin
      return 32'hDEAD_BEEF;
    end
  endfunction

  // Two-cycle BRAM: address registered in the DUT, data READ_LAT cycles later.
  always @(posedge clk) begin
    rd_p1 <= bram_model(bram_addr);
    rd_p2 <= rd_p1;
  end
  assign bram_dout = rd_p2;

  for (genvar g = 0; g < 3; g++) begin : g_lat
    logic [31:0] pipe [g+1];
    always @(posedge clk) begin
      pipe[0] <= 32'hC0DE_0000 + 32'(g + 1);
      for (int k = 1; k < g + 1; k++) pipe[k] <= pipe[k-1];
    end
    assign sm_dout[g] = pipe[g];
    fft_bram_axis_unloader #(
      .ADDR_W(14), .DATA_W(32), .N_WORDS(1), .BASE_ADDR(0),
      .ADDR_STEP(4), .READ_LAT(g + 1)
    ) u_sm (
      .clk(clk), .rstn(rstn), .start(sm_start[g]), .busy(sm_busy[g]),
      .done(sm_done[g]), .bram_we(sm_we[g]), .bram_addr(sm_addr[g]),
      .bram_din(sm_din[g]), .bram_dout(sm_dout[g]), .m_tdata(sm_tdata[g]),
      .m_tvalid(sm_tvalid[g]), .m_tready(1'b1), .m_tlast(sm_tlast[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), 32'(i)});
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      cyc++;
      if (cyc > limit) begin
        chk("done_timeout", 64'(cyc), 64'(limit));
        break;
      end
    end
  endtask

  task automatic wait_beats(input int n, input int limit);
    int cyc;
    cyc = 0;
    while (beats_seen < n) begin
      @(negedge clk);
      cyc++;
      if (cyc > limit) begin
        chk("beat_timeout", 64'(beats_seen), 64'(n));
        break;
      end
    end
  endtask

  // m_tready driver: 0 = always ready, 1 = ready low ~30%, 2 = held low.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       m_tready = ($urandom_range(0, 99) >= 30);
        2:       m_tready = 1'b0;
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard for the main instance.
  logic        prev_stall = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  logic [13:0] prev_addr = 14'(BASE);
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
      prev_addr  = 14'(BASE);
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(m_tvalid), 64'(1));
        chk("hold_data", 64'(m_tdata), 64'(held_data));
        chk("hold_last", 64'(m_tlast), 64'(held_last));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h with empty queue", m_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_tdata), 64'(e.data));
          chk("beat_last", 64'(m_tlast), 64'(e.last));
        end
        beats_seen++;
      end
      prev_stall = m_tvalid && !m_tready;
      held_data  = m_tdata;
      held_last  = m_tlast;
      if (dut.push_s) begin
        chk("fifo_no_overflow",
            64'((int'(dut.fifo_count_r) < DEPTH) || (m_tvalid && m_tready)), 64'(1));
      end
      if (bram_we !== 1'b0) chk("bram_we_zero", 64'(bram_we), 64'(0));
      if (bram_addr != prev_addr) begin
        chk("addr_step",
            64'((bram_addr == 14'(BASE)) || (bram_addr == prev_addr + 14'd4)), 64'(1));
      end
      prev_addr = bram_addr;
    end
  end

  initial begin
    int cyc, first_v, lat;
    logic bad;
    rstn = 1'b0;
    start = 1'b0;
    sm_start = 3'b000;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_tlast", 64'(m_tlast), 64'(0));
    chk("rst_tdata", 64'(m_tdata), 64'(0));
    chk("rst_addr", 64'(bram_addr), 64'(BASE));
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Latency sweep with single-word frames
    for (int r = 1; r <= 3; r++) begin
      @(posedge clk);
      #1 sm_start[r-1] = 1'b1;
      @(posedge clk);
      #1 sm_start[r-1] = 1'b0;
      lat = 0;
      while (1) begin
        @(negedge clk);
        if (sm_tvalid[r-1]) break;
        lat++;
        if (lat > 20) break;
      end
      chk($sformatf("sm%0d_latency", r), 64'(lat), 64'(r + 1));
      chk($sformatf("sm%0d_tdata", r), 64'(sm_tdata[r-1]), 64'(32'hC0DE_0000 + 32'(r)));
      chk($sformatf("sm%0d_tlast", r), 64'(sm_tlast[r-1]), 64'(1));
      @(negedge clk);
      chk($sformatf("sm%0d_done", r), 64'(sm_done[r-1]), 64'(1));
      chk($sformatf("sm%0d_tvalid_after", r), 64'(sm_tvalid[r-1]), 64'(0));
    end

    // Frame A: full rate, extra starts while busy
    push_frame();
    beats_seen = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    cyc = 0;
    first_v = -1;
    while (1) begin
      @(negedge clk);
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (done) break;
      start = (cyc == 50 || cyc == 300);
      cyc++;
      if (cyc > 5000) begin
        chk("frameA_timeout", 64'(cyc), 64'(0));
        break;
      end
    end
    chk("frameA_first_valid", 64'(first_v), 64'(RL + 1));
    chk("frameA_cycles", 64'(cyc), 64'(N + RL + 1));
    chk("frameA_beats", 64'(beats_seen), 64'(N));
    chk("frameA_busy_on_done", 64'(busy), 64'(0));

    // Frame B: back-to-back start on the done cycle, with backpressure
    start = 1'b1;
    push_frame();
    beats_seen = 0;
    rdy_mode = 1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("frameB_busy", 64'(busy), 64'(1));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
    wait_beats(200, 5000);
    rdy_mode = 2;
    repeat (20) @(posedge clk);
    rdy_mode = 1;
    wait_done(20000, cyc);
    chk("frameB_beats", 64'(beats_seen), 64'(N));
    chk("frameB_queue_empty", 64'(exp_q.size()), 64'(0));

    // Frame C: aborted by reset mid-stream
    rdy_mode = 0;
    push_frame();
    beats_seen = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_beats(100, 5000);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("abort_tvalid", 64'(m_tvalid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_tlast", 64'(m_tlast), 64'(0));
    chk("abort_addr", 64'(bram_addr), 64'(BASE));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || m_tvalid) bad = 1'b1;
    end
    chk("abort_quiet", 64'(bad), 64'(0));

    // Frame D: replay from word 0 after reset
    push_frame();
    beats_seen = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(5000, cyc);
    chk("frameD_cycles", 64'(cyc), 64'(N + RL + 1));
    chk("frameD_beats", 64'(beats_seen), 64'(N));
    chk("frameD_queue_empty", 64'(exp_q.size()), 64'(0));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
